ps2_key_event_decoder: RTL
==========================

Name: ps2_key_event_decoder

Overview:
Parametrised successor to the single-register keyboard decoder. It consumes the PS/2 scan-code byte stream from ps2_keyboard through the ready/nextdata_n handshake. It decodes set-2 make, break, E0-extended and E1 (Pause) sequences, and tracks modifier state. It optionally filters typematic repeats and pushes complete key events into a FIFO that CPU/MMIO logic pops.

Parameters:
FIFO_DEPTH, 8, number of buffered key events; power of two, at least 2
FILTER_REPEAT, 1, when 1, drops make codes that repeat the currently held last-pressed key
EMIT_PAUSE, 1, when 1, the E1 Pause sequence yields one event; when 0, it is swallowed

Ports:
clk  in  1  system clock
clrn  in  1  asynchronous active-low reset
rx_data  in  8  scan byte from ps2_keyboard.data
rx_ready  in  1  ps2_keyboard.ready; byte available
nextdata_n  out  1  pop strobe to ps2_keyboard, active low
ev_rd  in  1  pop head event; ignored when ev_valid=0
ev_valid  out  1  FIFO non-empty
ev_code  out  8  head event scan code (base byte, no prefix)
ev_ext  out  1  head event had an E0 prefix, or is Pause
ev_down  out  1  head event is make (1) or break (0)
mods  out  6  held modifiers {ralt,lalt,rctrl,lctrl,rshift,lshift}
ev_count  out  $clog2(FIFO_DEPTH)+1  events in FIFO
overflow  out  1  sticky: an event was dropped because the FIFO was full
ovf_clr  in  1  clears overflow

Behaviour:
- Reset (clrn=0, async): nextdata_n=1, FIFO empty, ev_valid=0, ev_count=0, ev_code/ev_ext/ev_down=0, mods=0, overflow=0, FSM=IDLE, last-held register invalid.
- Byte accept: if rx_ready=1 and nextdata_n=1, latch rx_data and drive nextdata_n=0 for exactly 1 cycle, then 1. Throughput is at most one byte per 2 cycles. Outside this handshake nextdata_n stays 1.
- FSM, evaluated on each accepted byte:
  - IDLE: F0 goes to BRK. E0 goes to EXT. E1 goes to PAUSE with skip counter 7. Any other byte emits make(code, ext=0) and stays in IDLE.
  - EXT: F0 goes to EXT_BRK. E0 stays in EXT. 12 (fake-shift) returns to IDLE with no event. Any other byte emits make(code, ext=1) and returns to IDLE.
  - BRK: emits break(code, ext=0) and returns to IDLE.
  - EXT_BRK: 12 returns to IDLE with no event. Any other byte emits break(code, ext=1) and returns to IDLE.
  - PAUSE: decrement the counter per byte. At 0, if EMIT_PAUSE, emit make(code=77, ext=1); return to IDLE. There is no break event for Pause.
- Event emission happens in the cycle after byte accept: 1-cycle latency, and ev_valid rises 2 cycles after the rx_ready-sampled edge when the FIFO was empty.
- Modifiers update on every decoded event, including repeat-filtered ones:
  - 12 -> lshift; 59 -> rshift
  - 14 -> lctrl; E0 14 -> rctrl
  - 11 -> lalt; E0 11 -> ralt
  - Make sets the bit, break clears it.
  - mods updates in the same cycle as the FIFO push, regardless of FIFO full.
- Repeat filter (FILTER_REPEAT=1):
  - Holds {last_ext, last_code, last_valid}.
  - A make equal to the held key is dropped. Any other make is pushed and becomes the held key.
  - A break equal to the held key clears last_valid. Every break is pushed.
  - With FILTER_REPEAT=0, every make is pushed.
- FIFO:
  - Circular buffer with read/write pointers of width $clog2(FIFO_DEPTH)+1.
  - Head outputs are show-ahead: valid combinationally from storage when ev_valid=1.
  - Push when full: event dropped, overflow<=1. If ev_rd is asserted in the same cycle, the pop frees a slot and the push succeeds, with no overflow.
  - Simultaneous push and pop when not empty: ev_count unchanged.
  - ev_rd when empty: no effect.
  - ovf_clr together with a new overflow: set wins.
- Pointer wrap at FIFO_DEPTH is natural modulo. Full means pointers equal except for the MSB.
- A mid-sequence reset (e.g. after E0) discards the partial sequence; the next byte is decoded from IDLE.

Decomposition:
- Package kbd_pkg:
  - scan constants: SC_BREAK=F0, SC_EXT=E0, SC_PAUSE=E1, SC_LSHIFT=12, SC_RSHIFT=59, SC_CTRL=14, SC_ALT=11, PAUSE_TAIL=7
  - decode-state enum {IDLE, EXT, BRK, EXT_BRK, PAUSE}
  - packed struct key_event_t {ext, down, code[7:0]}
- Sub-module key_event_fifo: parametrised by DEPTH and the key_event_t payload. It provides push/pop/full/empty/count and carries the drop-on-full and overflow logic.

Test Plan:
- Bytes 1C, F0 1C -> events (1C, ext0, down1), (1C, ext0, down0); ev_count=2; mods=0.
- Bytes E0 75, E0 F0 75 -> (75, ext1, down1), (75, ext1, down0).
- FILTER_REPEAT=1, bytes 12, 1C, 1C, 1C, F0 1C, F0 12 -> 4 events (12 make, 1C make, 1C break, 12 break). mods=000001 after the first byte and 000000 at the end.
- Bytes E1 14 77 E1 F0 14 F0 77 -> exactly 1 event (77, ext1, down1); mods unchanged; FSM back in IDLE, so a following 1C yields (1C, ext0, down1).
- FIFO_DEPTH=4, ev_rd=0, 5 distinct makes -> ev_count=4, overflow=1, head=first make. Then ev_rd for 4 cycles -> the 4 oldest events pop in order and ev_valid=0. ovf_clr -> overflow=0.
- Assert clrn=0 after E0 F0 -> all outputs at reset values. After release, 74 -> (74, ext0, down1).

Source files
------------

// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kbd_pkg
// Purpose  : Shared scan-code constants, decode states and key-event payload
//            for the PS/2 set-2 key event decoder.
// Revision : 1.0 - initial release
// ============================================================================
package kbd_pkg;

  // Set-2 prefix and modifier scan codes
  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_PAUSE   = 8'hE1;
  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;
  localparam logic [7:0] SC_CTRL    = 8'h14;
  localparam logic [7:0] SC_ALT     = 8'h11;

  // Code reported for the Pause key, and the number of bytes after E1
  localparam logic [7:0] SC_PAUSE_CODE = 8'h77;
  localparam logic [2:0] PAUSE_TAIL    = 3'd7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    PAUSE   = 3'd4
  } dec_state_e;

  typedef struct packed {
    logic       ext;
    logic       down;
    logic [7:0] code;
  } key_event_t;

  // One-hot modifier bit for an event: {ralt,lalt,rctrl,lctrl,rshift,lshift}
  function automatic logic [5:0] mod_mask(input key_event_t ev);
    logic [5:0] m;
    m = 6'b000000;
    if (!ev.ext) begin
      if (ev.code == SC_LSHIFT) m = 6'b000001;
      if (ev.code == SC_RSHIFT) m = 6'b000010;
      if (ev.code == SC_CTRL)   m = 6'b000100;
      if (ev.code == SC_ALT)    m = 6'b010000;
    end else begin
      if (ev.code == SC_CTRL)   m = 6'b001000;
      if (ev.code == SC_ALT)    m = 6'b100000;
    end
    return m;
  endfunction

endpackage : kbd_pkg
`default_nettype wire

// File: rtl/key_event_fifo.sv
`default_nettype none
// ============================================================================
// Module   : key_event_fifo
// Purpose  : Show-ahead circular FIFO of key events with drop-on-full and a
//            sticky overflow flag. A pop in the same cycle as a push into a
//            full FIFO frees the slot, so the push is kept.
// Revision : 1.0 - initial release
// ============================================================================
module key_event_fifo
  import kbd_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = key_event_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  T                         push_data_i,
  input  logic                     pop_i,
  input  logic                     ovf_clr_i,
  output T                         head_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        ovf_q, ovf_d;
  T            mem_q [DEPTH];

  logic        empty;
  logic        full;
  logic        do_pop;
  logic        do_push;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  // Pointer advance and overflow flag next-state; a new overflow beats a clear
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    if (ovf_clr_i) ovf_d = 1'b0;
    if (push_i && full && !do_pop) ovf_d = 1'b1;
  end

  // Pointer and overflow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  // Event storage; contents are only visible through the gated head
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

  assign head_o     = empty ? T'('0) : mem_q[rd_q[AW-1:0]];
  assign empty_o    = empty;
  assign count_o    = wr_q - rd_q;
  assign overflow_o = ovf_q;

endmodule : key_event_fifo
`default_nettype wire

// File: rtl/ps2_key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_event_decoder
// Purpose  : Accepts PS/2 set-2 scan bytes via the ready/nextdata_n handshake,
//            decodes make/break/E0/E1 sequences, tracks modifier keys,
//            optionally filters typematic repeats and queues key events.
//            Pipeline: accept byte -> decode event -> filter/push.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_event_decoder
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int FILTER_REPEAT = 1,
  parameter int EMIT_PAUSE    = 1
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_ready,
  output logic                          nextdata_n,
  input  logic                          ev_rd,
  output logic                          ev_valid,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_down,
  output logic [5:0]                    mods,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  // Handshake / byte capture
  logic        nextdata_n_q, nextdata_n_d;
  logic [7:0]  byte_q;
  logic        byte_vld_q;
  logic        accept;

  // Decoder
  dec_state_e  state_q, state_d;
  logic [2:0]  pcnt_q, pcnt_d;
  key_event_t  dec_ev;
  logic        dec_vld;
  key_event_t  ev_q;
  logic        ev_vld_q;

  // Repeat filter and modifiers
  logic        last_valid_q, last_valid_d;
  logic        last_ext_q, last_ext_d;
  logic [7:0]  last_code_q, last_code_d;
  logic [5:0]  mods_q, mods_d;
  logic        held_match;
  logic        drop;
  logic        push;

  key_event_t  head;
  logic        fifo_empty;

  assign accept       = rx_ready && nextdata_n_q;
  assign nextdata_n_d = !accept;

  // Byte capture: one-cycle low pulse on nextdata_n for every accepted byte
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      nextdata_n_q <= 1'b1;
      byte_q       <= 8'h00;
      byte_vld_q   <= 1'b0;
    end else begin
      nextdata_n_q <= nextdata_n_d;
      byte_vld_q   <= accept;
      if (accept) byte_q <= rx_data;
    end
  end

  // Decode next-state and event generation from the captured byte
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    dec_vld = 1'b0;
    dec_ev  = '0;
    if (byte_vld_q) begin
      case (state_q)
        IDLE: begin
          if (byte_q == SC_BREAK) begin
            state_d = BRK;
          end else if (byte_q == SC_EXT) begin
            state_d = EXT;
          end else if (byte_q == SC_PAUSE) begin
            state_d = PAUSE;
            pcnt_d  = PAUSE_TAIL;
          end else begin
            dec_vld = 1'b1;
            dec_ev  = '{ext: 1'b0, down: 1'b1, code: byte_q};
          end
        end
        EXT: begin
          if (byte_q == SC_BREAK) begin
            state_d = EXT_BRK;
          end else if (byte_q == SC_EXT) begin
            state_d = EXT;
          end else begin
            // E0 12 is the fake shift some keyboards wrap around E0 keys
            state_d = IDLE;
            if (byte_q != SC_LSHIFT) begin
              dec_vld = 1'b1;
              dec_ev  = '{ext: 1'b1, down: 1'b1, code: byte_q};
            end
          end
        end
        BRK: begin
          state_d = IDLE;
          dec_vld = 1'b1;
          dec_ev  = '{ext: 1'b0, down: 1'b0, code: byte_q};
        end
        EXT_BRK: begin
          state_d = IDLE;
          if (byte_q != SC_LSHIFT) begin
            dec_vld = 1'b1;
            dec_ev  = '{ext: 1'b1, down: 1'b0, code: byte_q};
          end
        end
        PAUSE: begin
          // Swallow the fixed-length tail; the last byte yields the event
          if (pcnt_q == 3'd1) begin
            state_d = IDLE;
            pcnt_d  = 3'd0;
            dec_vld = (EMIT_PAUSE != 0);
            dec_ev  = '{ext: 1'b1, down: 1'b1, code: SC_PAUSE_CODE};
          end else begin
            pcnt_d = pcnt_q - 3'd1;
          end
        end
        default: begin
          state_d = IDLE;
          pcnt_d  = 3'd0;
        end
      endcase
    end
  end

  // Decoder state and registered decoded event
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= IDLE;
      pcnt_q   <= 3'd0;
      ev_q     <= '0;
      ev_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      ev_q     <= dec_ev;
      ev_vld_q <= dec_vld;
    end
  end

  assign held_match = last_valid_q && (last_ext_q == ev_q.ext) && (last_code_q == ev_q.code);
  assign drop       = (FILTER_REPEAT != 0) && ev_q.down && held_match;
  assign push       = ev_vld_q && !drop;

  // Held-key tracking and modifier update for each decoded event
  always_comb begin
    last_valid_d = last_valid_q;
    last_ext_d   = last_ext_q;
    last_code_d  = last_code_q;
    mods_d       = mods_q;
    if (ev_vld_q) begin
      if (ev_q.down) begin
        mods_d = mods_q | mod_mask(ev_q);
        if (!drop) begin
          last_valid_d = 1'b1;
          last_ext_d   = ev_q.ext;
          last_code_d  = ev_q.code;
        end
      end else begin
        mods_d = mods_q & ~mod_mask(ev_q);
        if (held_match) last_valid_d = 1'b0;
      end
    end
  end

  // Held-key and modifier registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      last_valid_q <= 1'b0;
      last_ext_q   <= 1'b0;
      last_code_q  <= 8'h00;
      mods_q       <= 6'b000000;
    end else begin
      last_valid_q <= last_valid_d;
      last_ext_q   <= last_ext_d;
      last_code_q  <= last_code_d;
      mods_q       <= mods_d;
    end
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (key_event_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (clrn),
    .push_i      (push),
    .push_data_i (ev_q),
    .pop_i       (ev_rd),
    .ovf_clr_i   (ovf_clr),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .count_o     (ev_count),
    .overflow_o  (overflow)
  );

  assign nextdata_n = nextdata_n_q;
  assign ev_valid   = !fifo_empty;
  assign ev_code    = head.code;
  assign ev_ext     = head.ext;
  assign ev_down    = head.down;
  assign mods       = mods_q;

endmodule : ps2_key_event_decoder
`default_nettype wire
